// File: rtl/pattern_player_if.sv
// Fetch handshake between the pattern player (master) and the SRAM bar reader (slave).
// Signal names are seen from the player's side.
interface pattern_player_if;
  localparam int unsigned BAR_W = 4;
  localparam int unsigned PAT_W = 64;

  logic             o_req;
  logic [BAR_W-1:0] o_bar;
  logic [PAT_W-1:0] i_data;
  logic             i_finish;

  modport master (output o_req, o_bar, input  i_data, i_finish);
  modport slave  (input  o_req, o_bar, output i_data, i_finish);
endinterface

// File: rtl/pattern_player.sv
// Double-buffered bar pattern sequencer: fetches 64-bit bars from the reader and
// plays them as 16 steps x 4 tracks of one-cycle trigger pulses.
module pattern_player #(
  parameter int unsigned STEPS    = 16,
  parameter int unsigned TRACKS   = 4,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                i_bclk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_step_period,
  input  logic [3:0]          i_last_bar,
  pattern_player_if.master    bus,
  output logic [TRACKS-1:0]   o_trig,
  output logic [3:0]          o_step,
  output logic [3:0]          o_cur_bar,
  output logic                o_busy,
  output logic                o_underrun
);
  localparam int unsigned PAT_W  = STEPS * TRACKS;
  localparam int unsigned IDX_W  = $clog2(PAT_W);
  localparam int unsigned STEP_W = 4;
  localparam int unsigned BAR_W  = 4;

  typedef enum logic [1:0] {IDLE, FETCH0, PLAY, STALL} state_t;

  state_t              state_q;
  logic [PAT_W-1:0]    act_q, nxt_q;
  logic                next_valid_q, req_pending_q, pf_due_q;
  logic [PERIOD_W-1:0] tick_q, period_q;
  logic [STEP_W-1:0]   step_q;
  logic [BAR_W-1:0]    cur_bar_q, bar_q;
  logic [TRACKS-1:0]   trig_q;
  logic                req_q, busy_q, underrun_q;

  logic                fin_c, step_end_c, bar_end_c, load_bar_c;
  logic [PAT_W-1:0]    src_c;
  logic [STEP_W-1:0]   step_inc_c;
  logic [PERIOD_W-1:0] period_c;
  logic [BAR_W-1:0]    next_bar_c;

  // A finish only counts while we are actually waiting for one.
  assign fin_c      = bus.i_finish && req_pending_q;
  assign step_end_c = (tick_q == period_q - PERIOD_W'(1));
  assign bar_end_c  = step_end_c && (step_q == STEP_W'(STEPS - 1));
  assign load_bar_c = (((state_q == FETCH0) || (state_q == STALL)) && fin_c) ||
                      ((state_q == PLAY) && bar_end_c && (next_valid_q || fin_c));
  // A finish landing on the bar boundary is used directly instead of via the next buffer.
  assign src_c      = next_valid_q ? nxt_q : bus.i_data;
  assign step_inc_c = step_q + STEP_W'(1);
  assign period_c   = (i_step_period == '0) ? PERIOD_W'(1) : i_step_period;
  assign next_bar_c = (cur_bar_q == i_last_bar) ? BAR_W'(0) : cur_bar_q + BAR_W'(1);

  always_ff @(posedge i_bclk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      act_q         <= '0;
      nxt_q         <= '0;
      next_valid_q  <= 1'b0;
      req_pending_q <= 1'b0;
      pf_due_q      <= 1'b0;
      tick_q        <= '0;
      period_q      <= '0;
      step_q        <= '0;
      cur_bar_q     <= '0;
      bar_q         <= '0;
      trig_q        <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      trig_q <= '0;
      req_q  <= 1'b0;
      if ((state_q != IDLE) && !i_run) begin
        state_q       <= IDLE;
        busy_q        <= 1'b0;
        req_pending_q <= 1'b0;
        next_valid_q  <= 1'b0;
        pf_due_q      <= 1'b0;
        tick_q        <= '0;
        step_q        <= '0;
        cur_bar_q     <= '0;
        underrun_q    <= 1'b0;
      end else if (load_bar_c) begin
        // Start step 0 of a freshly arrived or prefetched bar.
        state_q       <= PLAY;
        act_q         <= src_c;
        trig_q        <= src_c[TRACKS-1:0];
        cur_bar_q     <= bar_q;
        next_valid_q  <= 1'b0;
        req_pending_q <= 1'b0;
        step_q        <= '0;
        tick_q        <= '0;
        period_q      <= period_c;
        pf_due_q      <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            step_q     <= '0;
            cur_bar_q  <= '0;
            underrun_q <= 1'b0;
            if (i_run) begin
              state_q       <= FETCH0;
              busy_q        <= 1'b1;
              req_q         <= 1'b1;
              bar_q         <= '0;
              req_pending_q <= 1'b1;
            end
          end
          PLAY: begin
            if (pf_due_q) begin
              pf_due_q <= 1'b0;
              if (!req_pending_q && !next_valid_q) begin
                req_q         <= 1'b1;
                bar_q         <= next_bar_c;
                req_pending_q <= 1'b1;
              end
            end
            if (fin_c) begin
              nxt_q         <= bus.i_data;
              next_valid_q  <= 1'b1;
              req_pending_q <= 1'b0;
            end
            if (bar_end_c) begin
              underrun_q <= 1'b1;
              state_q    <= STALL;
            end else if (step_end_c) begin
              step_q   <= step_inc_c;
              trig_q   <= act_q[IDX_W'(int'(step_inc_c) * TRACKS) +: TRACKS];
              tick_q   <= '0;
              period_q <= period_c;
            end else begin
              tick_q <= tick_q + PERIOD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_req  = req_q;
  assign bus.o_bar  = bar_q;
  assign o_trig     = trig_q;
  assign o_step     = step_q;
  assign o_cur_bar  = cur_bar_q;
  assign o_busy     = busy_q;
  assign o_underrun = underrun_q;
endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player with a fixed-latency reader model.
module tb_pattern_player;
  logic        i_bclk = 1'b0;
  logic        i_rst;
  logic        i_run;
  logic [23:0] i_step_period;
  logic [3:0]  i_last_bar;
  logic [3:0]  o_trig, o_step, o_cur_bar;
  logic        o_busy, o_underrun;

  pattern_player_if rd_if ();

  pattern_player #(.STEPS(16), .TRACKS(4), .PERIOD_W(24)) dut (
    .i_bclk        (i_bclk),
    .i_rst         (i_rst),
    .i_run         (i_run),
    .i_step_period (i_step_period),
    .i_last_bar    (i_last_bar),
    .bus           (rd_if.master),
    .o_trig        (o_trig),
    .o_step        (o_step),
    .o_cur_bar     (o_cur_bar),
    .o_busy        (o_busy),
    .o_underrun    (o_underrun)
  );

  always #5 i_bclk = ~i_bclk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_delay = 3;
  int          rd_cnt   = 0;
  logic [63:0] rd_pat [16];

  // Reader: answers each request rd_delay cycles later; a new request restarts it.
  always @(negedge i_bclk) begin
    rd_if.i_finish = 1'b0;
    if (i_rst) begin
      rd_cnt = 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt = rd_cnt - 1;
        if (rd_cnt == 0) begin
          rd_if.i_finish = 1'b1;
          rd_if.i_data   = rd_pat[rd_if.o_bar];
        end
      end
      if (rd_if.o_req) rd_cnt = rd_delay;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge i_bclk);
      n++;
    end while (!rd_if.o_req && n < budget);
    check(tag, 64'(rd_if.o_req), 64'd1);
  endtask

  task automatic wait_trig(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge i_bclk);
      n++;
    end while (o_trig == 4'h0 && n < budget);
    check(tag, 64'(o_trig != 4'h0), 64'd1);
  endtask

  task automatic go_idle();
    i_run = 1'b0;
    repeat (2) @(negedge i_bclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [63:0] acc;
    logic [3:0]  eb;

    i_rst = 1'b1; i_run = 1'b0; i_step_period = 24'd4; i_last_bar = 4'd0;
    rd_if.i_data = '0; rd_if.i_finish = 1'b0;
    for (int b = 0; b < 16; b++) rd_pat[b] = {4'h8, 56'h0, 4'(b + 1)};
    repeat (3) @(negedge i_bclk);
    check("rst_req",  64'(rd_if.o_req), 64'd0);
    check("rst_outs", 64'({rd_if.o_bar, o_trig, o_step, o_cur_bar, o_busy, o_underrun}), 64'd0);
    i_rst = 1'b0;
    @(negedge i_bclk);
    check("idle_busy", 64'(o_busy), 64'd0);

    // Basic fetch, single-bar song, period 4
    rd_pat[0] = 64'h0000_0000_0000_000F;
    i_run = 1'b1;
    wait_req("s1_req_seen", 8, n);
    check("s1_req_lat", 64'(n), 64'd1);
    check("s1_bar", 64'(rd_if.o_bar), 64'd0);
    check("s1_busy", 64'(o_busy), 64'd1);
    wait_trig("s1_trig_seen", 10, n);
    check("s1_req_to_trig", 64'(n), 64'd4);
    check("s1_trig0", 64'(o_trig), 64'hF);
    check("s1_step0", 64'(o_step), 64'd0);
    @(negedge i_bclk);
    check("s1_prefetch_req", 64'(rd_if.o_req), 64'd1);
    check("s1_prefetch_bar", 64'(rd_if.o_bar), 64'd0);
    acc = 64'(o_trig);
    for (int rel = 2; rel <= 64; rel++) begin
      @(negedge i_bclk);
      if (rel < 64) begin
        acc = acc | 64'(o_trig);
        if (rel % 4 == 0) check("s1_step", 64'(o_step), 64'(rel / 4));
      end
    end
    check("s1_quiet_steps", acc, 64'd0);
    check("s1_wrap_trig", 64'(o_trig), 64'hF);
    check("s1_wrap_step", 64'(o_step), 64'd0);
    check("s1_wrap_bar", 64'(o_cur_bar), 64'd0);
    check("s1_underrun", 64'(o_underrun), 64'd0);

    // Bar wrap over three bars, period 2
    go_idle();
    check("s2_idle_busy", 64'(o_busy), 64'd0);
    rd_pat[0] = {4'h8, 56'h0, 4'h1};
    i_last_bar = 4'd2; rd_delay = 5; i_step_period = 24'd2;
    i_run = 1'b1;
    wait_trig("s2_trig_seen", 20, n);
    check("s2_first_trig", 64'(o_trig), 64'h1);
    check("s2_first_bar", 64'(o_cur_bar), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      eb = 4'(k % 3);
      repeat (30) @(negedge i_bclk);
      check("s2_step15", 64'(o_step), 64'd15);
      check("s2_trig15", 64'(o_trig), 64'h8);
      repeat (2) @(negedge i_bclk);
      check("s2_next_step0", 64'(o_step), 64'd0);
      check("s2_next_trig", 64'(o_trig), 64'(eb + 4'd1));
      check("s2_cur_bar", 64'(o_cur_bar), 64'(eb));
    end
    check("s2_underrun", 64'(o_underrun), 64'd0);

    // Underrun: slow reader, period 1
    go_idle();
    i_last_bar = 4'd1; rd_delay = 40; i_step_period = 24'd1;
    i_run = 1'b1;
    wait_trig("s3_trig_seen", 60, n);
    check("s3_first_trig", 64'(o_trig), 64'h1);
    repeat (15) @(negedge i_bclk);
    check("s3_step15", 64'(o_trig), 64'h8);
    @(negedge i_bclk);
    check("s3_underrun", 64'(o_underrun), 64'd1);
    check("s3_stall_trig", 64'(o_trig), 64'd0);
    check("s3_stall_busy", 64'(o_busy), 64'd1);
    check("s3_stall_step", 64'(o_step), 64'd15);
    wait_trig("s3_resume_seen", 40, n);
    check("s3_resume_lat", 64'(n), 64'd26);
    check("s3_resume_trig", 64'(o_trig), 64'h2);
    check("s3_resume_bar", 64'(o_cur_bar), 64'd1);
    check("s3_sticky", 64'(o_underrun), 64'd1);

    // Finish lands exactly on the bar boundary
    go_idle();
    check("s4_idle_underrun", 64'(o_underrun), 64'd0);
    rd_delay = 14;
    i_run = 1'b1;
    wait_trig("s4_trig_seen", 30, n);
    check("s4_first_trig", 64'(o_trig), 64'h1);
    repeat (15) @(negedge i_bclk);
    check("s4_step15", 64'(o_trig), 64'h8);
    @(negedge i_bclk);
    check("s4_step0", 64'(o_step), 64'd0);
    check("s4_trig", 64'(o_trig), 64'h2);
    check("s4_bar", 64'(o_cur_bar), 64'd1);
    check("s4_underrun", 64'(o_underrun), 64'd0);

    // Stop during an outstanding request, finish arrives afterwards
    go_idle();
    rd_delay = 3; i_step_period = 24'd4; i_last_bar = 4'd0;
    i_run = 1'b1;
    wait_req("s5_req_seen", 8, n);
    check("s5_bar", 64'(rd_if.o_bar), 64'd0);
    i_run = 1'b0;
    @(negedge i_bclk);
    check("s5_busy", 64'(o_busy), 64'd0);
    acc = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_bclk);
      acc = acc | 64'({rd_if.o_req, o_busy, o_trig});
    end
    check("s5_quiet", acc, 64'd0);

    // Asynchronous reset in the middle of a bar
    i_step_period = 24'd2;
    i_run = 1'b1;
    wait_trig("s6_trig_seen", 20, n);
    repeat (14) @(negedge i_bclk);
    check("s6_step7", 64'(o_step), 64'd7);
    i_rst = 1'b1;
    #1;
    check("s6_rst_outs", 64'({rd_if.o_req, rd_if.o_bar, o_trig, o_step, o_cur_bar, o_busy, o_underrun}), 64'd0);
    acc = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_bclk);
      acc = acc | 64'({rd_if.o_req, o_busy});
    end
    check("s6_rst_quiet", acc, 64'd0);
    i_rst = 1'b0;
    wait_req("s6_req_seen", 5, n);
    check("s6_req_lat", 64'(n), 64'd1);
    check("s6_bar", 64'(rd_if.o_bar), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
